// File: rtl/uart_tx.sv
// UART transmitter: serializes a parallel word as start, LSB-first data,
// optional parity and stop bits, one bit per clk cycle.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par;
  logic                  r_par_en;

  logic [CNT_W-1:0]      w_next_cnt;
  logic                  w_last_bit;

  assign w_next_cnt = r_cnt + 1'b1;
  assign w_last_bit = (r_cnt == CNT_W'(DATA_WIDTH - 1));

  // Outputs are loaded with the value for the state being entered, so the
  // line changes on the same edge as the state and never glitches.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_cnt    <= '0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            r_data   <= P_DATA;
            r_par_en <= PAR_EN;
            r_par    <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            r_state  <= S_START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_DATA;
          TX_OUT  <= r_data[0];
        end
        S_DATA: begin
          // r_cnt tracks the data bit currently on the line
          if (w_last_bit) begin
            if (r_par_en) begin
              r_state <= S_PARITY;
              TX_OUT  <= r_par;
            end else begin
              r_state <= S_STOP;
              TX_OUT  <= 1'b1;
            end
          end else begin
            r_cnt  <= w_next_cnt;
            TX_OUT <= r_data[w_next_cnt];
          end
        end
        S_PARITY: begin
          r_state <= S_STOP;
          TX_OUT  <= 1'b1;
        end
        S_STOP: begin
          r_state <= S_IDLE;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
